// File: rtl/ysyx_23060278_lsu.sv
// Load/store unit: serialises one memory op at a time over a valid/ready data port, aligns stores, extends loads.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned h/w accesses (misalign port) instead of forcing alignment.
module ysyx_23060278_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp_err,
  output logic        done,
  output logic        w_load,
  output logic [31:0] load_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        err
);

  // state | meaning
  // IDLE  | ready for a new op
  // REQ   | bus request presented, waiting for mem_req_ready
  // WAIT  | request taken, waiting for mem_resp_valid
  // DONE  | one-cycle result pulse
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic        op_load, op_store;
  logic [2:0]  op_f3;
  logic [31:0] op_addr, op_sd;
  logic        err_q, err_next;
  logic [31:0] ld_q, ld_next;
  logic        bad_op, req_mis, timeout_hit;
  logic [1:0]  off;
  logic [31:0] sh, ld_ext, st_data;
  logic [3:0]  st_strb;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        mis_q, mis_next;
`endif

  assign bad_op = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
                  (is_store && funct3[2]) || (is_load == is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis = ((funct3[1:0] == 2'd1) && addr[0]) ||
                   ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00));
`else
  assign req_mis = 1'b0;
`endif

  // Misaligned low bits are dropped so h/w always hit their natural lane.
  always_comb begin
    case (op_f3[1:0])
      2'd0:    off = op_addr[1:0];
      2'd1:    off = {op_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    case (op_f3[1:0])
      2'd0: begin
        st_data = {4{op_sd[7:0]}};
        st_strb = 4'b0001 << off;
      end
      2'd1: begin
        st_data = {2{op_sd[15:0]}};
        st_strb = 4'b0011 << off;
      end
      default: begin
        st_data = op_sd;
        st_strb = 4'b1111;
      end
    endcase
  end

  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    case (op_f3)
      3'd0:    ld_ext = {{24{sh[7]}}, sh[7:0]};
      3'd4:    ld_ext = {24'h0, sh[7:0]};
      3'd1:    ld_ext = {{16{sh[15]}}, sh[15:0]};
      3'd5:    ld_ext = {16'h0, sh[15:0]};
      default: ld_ext = sh;
    endcase
  end

  assign timeout_hit = (cnt >= 8'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err_q;
    ld_next    = ld_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_next   = mis_q;
`endif
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_next = 8'd0;
          err_next = 1'b0;
          ld_next  = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_next = 1'b0;
`endif
          if (bad_op) begin
            state_next = S_DONE;
            err_next   = 1'b1;
          end else if (req_mis) begin
            state_next = S_DONE;
            err_next   = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_next   = 1'b1;
`endif
          end else begin
            state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_next = cnt + 8'd1;
        // A completed handshake wins over the timeout: the bus already owns the request.
        if (mem_req_ready) begin
          state_next = S_WAIT;
        end else if (timeout_hit) begin
          state_next = S_DONE;
          err_next   = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_next = cnt + 8'd1;
        if (mem_resp_valid) begin
          state_next = S_DONE;
          err_next   = mem_resp_err;
          ld_next    = (mem_resp_err || !op_load) ? 32'h0 : ld_ext;
        end else if (timeout_hit) begin
          state_next = S_DONE;
          err_next   = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
      err_q <= 1'b0;
      ld_q  <= 32'h0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err_q <= err_next;
      ld_q  <= ld_next;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= mis_next;
  end
  assign misalign = (state == S_DONE) && mis_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_load  <= 1'b0;
      op_store <= 1'b0;
      op_f3    <= 3'd0;
      op_addr  <= 32'h0;
      op_sd    <= 32'h0;
    end else if (req_valid && req_ready) begin
      op_load  <= is_load;
      op_store <= is_store;
      op_f3    <= funct3;
      op_addr  <= addr;
      op_sd    <= store_data;
    end
  end

  assign req_ready     = (state == S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign mem_addr      = mem_req_valid ? {op_addr[31:2], 2'b00} : 32'h0;
  assign mem_wen       = mem_req_valid && op_store;
  assign mem_wdata     = mem_wen ? st_data : 32'h0;
  assign mem_wstrb     = mem_wen ? st_strb : 4'b0000;
  assign done          = (state == S_DONE);
  assign err           = done && err_q;
  assign w_load        = done && op_load && !err_q;
  assign load_data     = done ? ld_q : 32'h0;

endmodule
